// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
//   Bundles the instruction-cache side buses:
//     IF -> IC : IFIC_en (level request), IFIC_addr (fetch PC)
//     IC -> IF : ICIF_en (one-cycle data-valid pulse), ICIF_data (instruction)
//     ROB-> IC : ROBIC_clear (squash pending answer)
//     IC -> MC : ICMC_en (block-read request), ICMC_addr (block base address)
//     MC -> IC : MCIC_en (one-cycle block-valid pulse), MCIC_block (block data)
//   modport slave  : the cache's view.
//   modport master : the environment's view (fetcher + ROB + memory controller).
// ---------------------------------------------------------------------------
interface icache_direct_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_BITS = 64
);
    logic                  IFIC_en;
    logic [ADDR_WIDTH-1:0] IFIC_addr;
    logic                  ICIF_en;
    logic [31:0]           ICIF_data;
    logic                  ROBIC_clear;
    logic                  ICMC_en;
    logic [ADDR_WIDTH-1:0] ICMC_addr;
    logic                  MCIC_en;
    logic [BLOCK_BITS-1:0] MCIC_block;

    modport slave (
        input  IFIC_en, IFIC_addr, ROBIC_clear, MCIC_en, MCIC_block,
        output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
    );

    modport master (
        output IFIC_en, IFIC_addr, ROBIC_clear, MCIC_en, MCIC_block,
        input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
    );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache. One 32-bit instruction per
//   request; a miss fetches a whole block from the memory controller, fills
//   the line and then answers the fetcher. ROBIC_clear squashes the pending
//   answer without aborting or corrupting the fill.
// Ports:
//   Sys_clk : clock, rising edge
//   Sys_rst : asynchronous active-low reset
//   Sys_rdy : global enable; when low all state, arrays and outputs hold
//   bus     : icache_direct_if.slave (IF / ROB / MC handshakes)
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int BLOCK_WIDTH = 1,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
    parameter int CACHE_WIDTH = 8,
    parameter int BLOCK_NUM   = 1 << CACHE_WIDTH,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    icache_direct_if.slave        bus
);
    localparam int INDEX_LSB  = 2 + BLOCK_WIDTH;
    localparam int TAG_LSB    = INDEX_LSB + CACHE_WIDTH;
    localparam int TAG_W      = ADDR_WIDTH - TAG_LSB;
    localparam int BLOCK_BITS = 32 * BLOCK_SIZE;

    typedef enum logic {ST_IDLE, ST_MISS} state_t;

    state_t                  state_q, state_d;
    logic [BLOCK_NUM-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]        req_tag_q, req_tag_d;
    logic [CACHE_WIDTH-1:0]  req_idx_q, req_idx_d;
    logic [BLOCK_WIDTH-1:0]  req_off_q, req_off_d;
    logic [ADDR_WIDTH-1:0]   icmc_addr_q, icmc_addr_d;
    logic                    icif_en_q, icif_en_d;
    logic [31:0]             icif_data_q, icif_data_d;
    logic                    squash_q, squash_d;
    logic                    fill_we;

    // Tag and data storage are deliberately not reset; valid bits gate them.
    logic [TAG_W-1:0]        tag_mem  [BLOCK_NUM];
    logic [BLOCK_BITS-1:0]   data_mem [BLOCK_NUM];

    // Fields of the incoming request.
    logic [TAG_W-1:0]        cur_tag;
    logic [CACHE_WIDTH-1:0]  cur_idx;
    logic [BLOCK_WIDTH-1:0]  cur_off;
    logic                    hit;
    logic [BLOCK_BITS-1:0]   line_blk;
    logic [31:0]             line_word [BLOCK_SIZE];
    logic [31:0]             fill_word [BLOCK_SIZE];
    logic                    unused_addr_bits;

    assign cur_tag  = bus.IFIC_addr[ADDR_WIDTH-1:TAG_LSB];
    assign cur_idx  = bus.IFIC_addr[TAG_LSB-1:INDEX_LSB];
    assign cur_off  = bus.IFIC_addr[INDEX_LSB-1:2];
    assign unused_addr_bits = ^bus.IFIC_addr[1:0];
    assign line_blk = data_mem[cur_idx];
    assign hit      = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    // The MC delivers byte base+k at the top of the block going down; each
    // instruction is the little-endian assembly of its four bytes.
    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_word
            localparam int HI = BLOCK_BITS - 1 - 32 * gi;
            assign line_word[gi] = {line_blk[HI-24 -: 8], line_blk[HI-16 -: 8],
                                    line_blk[HI-8 -: 8],  line_blk[HI -: 8]};
            assign fill_word[gi] = {bus.MCIC_block[HI-24 -: 8], bus.MCIC_block[HI-16 -: 8],
                                    bus.MCIC_block[HI-8 -: 8],  bus.MCIC_block[HI -: 8]};
        end
    endgenerate

    // Combinational so the request is already withdrawn on the MC's
    // delivery cycle and no second transfer is launched.
    assign bus.ICMC_en   = (state_q == ST_MISS) && !bus.MCIC_en;
    assign bus.ICMC_addr = icmc_addr_q;
    assign bus.ICIF_en   = icif_en_q;
    assign bus.ICIF_data = icif_data_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_off_d   = req_off_q;
        icmc_addr_d = icmc_addr_q;
        icif_en_d   = icif_en_q;
        icif_data_d = icif_data_q;
        squash_d    = squash_q;
        fill_we     = 1'b0;

        if (Sys_rdy) begin
            icif_en_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A clear in IDLE suppresses both a hit answer and a new miss.
                    if (bus.IFIC_en && !bus.ROBIC_clear) begin
                        if (hit) begin
                            icif_en_d   = 1'b1;
                            icif_data_d = line_word[cur_off];
                        end else begin
                            req_tag_d   = cur_tag;
                            req_idx_d   = cur_idx;
                            req_off_d   = cur_off;
                            icmc_addr_d = {bus.IFIC_addr[ADDR_WIDTH-1:INDEX_LSB],
                                           {INDEX_LSB{1'b0}}};
                            state_d     = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (bus.MCIC_en) begin
                        fill_we            = 1'b1;
                        valid_d[req_idx_q] = 1'b1;
                        state_d            = ST_IDLE;
                        squash_d           = 1'b0;
                        if (!(squash_q || bus.ROBIC_clear)) begin
                            icif_en_d   = 1'b1;
                            icif_data_d = fill_word[req_off_q];
                        end
                    end else if (bus.ROBIC_clear) begin
                        squash_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_off_q   <= '0;
            icmc_addr_q <= '0;
            icif_en_q   <= 1'b0;
            icif_data_q <= '0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_off_q   <= req_off_d;
            icmc_addr_q <= icmc_addr_d;
            icif_en_q   <= icif_en_d;
            icif_data_q <= icif_data_d;
            squash_q    <= squash_d;
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (fill_we) begin
            tag_mem[req_idx_q]  <= req_tag_q;
            data_mem[req_idx_q] <= bus.MCIC_block;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    icache_direct_if bus();

    icache_direct dut (
        .Sys_clk (clk),
        .Sys_rst (rst_n),
        .Sys_rdy (rdy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per-line valid/tag, and a byte-addressed backing memory.
    bit          m_valid [256];
    logic [20:0] m_tag   [256];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] r;
        case (a)
            32'h1000: r = 8'h13;
            32'h1001: r = 8'h05;
            32'h1002: r = 8'h00;
            32'h1003: r = 8'h00;
            32'h1004: r = 8'h93;
            32'h1005: r = 8'h00;
            32'h1006: r = 8'h10;
            32'h1007: r = 8'h00;
            default:  r = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5a;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] mem_block(input logic [31:0] base);
        logic [63:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) b[63-8*k -: 8] = mem_byte(base + 32'(k));
        return b;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction. lat = MC cycles until MCIC_en; clear_at = cycle
    // (counted from the cycle ICMC_en is first seen) to pulse ROBIC_clear, or -1.
    task automatic fetch(input logic [31:0] a, input int lat, input int clear_at);
        logic [7:0]  idx;
        logic [20:0] tg;
        logic [31:0] base;
        bit          exp_hit;
        bit          squashed;
        idx     = a[10:3];
        tg      = a[31:11];
        base    = {a[31:3], 3'b000};
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        squashed = 1'b0;
        bus.IFIC_en   = 1'b1;
        bus.IFIC_addr = a;
        tick();
        if (exp_hit) begin
            chk("hit_en",    bus.ICIF_en,   1);
            chk("hit_data",  bus.ICIF_data, word_at(a));
            chk("hit_no_mc", bus.ICMC_en,   0);
            bus.IFIC_en = 1'b0;
        end else begin
            chk("miss_no_resp", bus.ICIF_en,   0);
            chk("miss_req",     bus.ICMC_en,   1);
            chk("miss_addr",    bus.ICMC_addr, base);
            for (int c = 0; c < lat; c++) begin
                if (c > 0) begin
                    chk("mc_wait_req",  bus.ICMC_en, 1);
                    chk("mc_wait_resp", bus.ICIF_en, 0);
                end
                if (c == clear_at) begin
                    bus.ROBIC_clear = 1'b1;
                    bus.IFIC_en     = 1'b0;
                    bus.IFIC_addr   = $urandom;
                    squashed        = 1'b1;
                end
                if (c == lat - 1) begin
                    bus.MCIC_en    = 1'b1;
                    bus.MCIC_block = mem_block(base);
                    #1;
                    chk("mc_req_low_on_fill", bus.ICMC_en, 0);
                end
                tick();
                bus.ROBIC_clear = 1'b0;
                bus.MCIC_en     = 1'b0;
                bus.MCIC_block  = {$urandom, $urandom};
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            if (squashed) begin
                chk("squash_no_resp", bus.ICIF_en, 0);
            end else begin
                chk("fill_resp_en",   bus.ICIF_en,   1);
                chk("fill_resp_data", bus.ICIF_data, word_at(a));
            end
            bus.IFIC_en = 1'b0;
        end
        $display("fetch addr=%h hit=%0d lat=%0d clear_at=%0d exp_data=%h", a, exp_hit, lat,
                 clear_at, word_at(a));
        tick();
        chk("resp_is_pulse", bus.ICIF_en, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          lat;
        int          clr;
        logic [20:0] tags [3];
        logic [7:0]  idxs [3];
        tags[0] = 21'h2;  tags[1] = 21'h3;  tags[2] = 21'h7;
        idxs[0] = 8'h10;  idxs[1] = 8'h11;  idxs[2] = 8'h55;

        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        rst_n           = 1'b1;
        rdy             = 1'b1;
        bus.IFIC_en     = 1'b0;
        bus.IFIC_addr   = '0;
        bus.ROBIC_clear = 1'b0;
        bus.MCIC_en     = 1'b0;
        bus.MCIC_block  = '0;

        // Reset values, observed without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_icif_en",   bus.ICIF_en,   0);
        chk("rst_icif_data", bus.ICIF_data, 0);
        chk("rst_icmc_en",   bus.ICMC_en,   0);
        chk("rst_icmc_addr", bus.ICMC_addr, 0);
        #9 rst_n = 1'b1;
        tick();

        // Cold miss, hit after fill, conflict eviction and re-miss.
        fetch(32'h0000_1004, 3, -1);
        chk("cold_word_const", word_at(32'h0000_1004), 32'h0010_0093);
        fetch(32'h0000_1000, 2, -1);
        chk("hit_word_const", word_at(32'h0000_1000), 32'h0000_0513);
        fetch(32'h0000_1800, 2, -1);
        fetch(32'h0000_1000, 1, -1);

        // Flush two cycles into a miss, then the same block hits.
        fetch(32'h0000_2010, 5, 2);
        fetch(32'h0000_2014, 1, -1);

        // Clear coincident with fill: no answer, line valid afterwards.
        fetch(32'h0000_3028, 3, 2);
        fetch(32'h0000_3028, 1, -1);

        // Clear in IDLE on a would-be hit: no answer that cycle.
        bus.IFIC_en     = 1'b1;
        bus.IFIC_addr   = 32'h0000_3028;
        bus.ROBIC_clear = 1'b1;
        tick();
        chk("idle_clear_no_resp", bus.ICIF_en, 0);
        chk("idle_clear_no_mc",   bus.ICMC_en, 0);
        bus.ROBIC_clear = 1'b0;
        tick();
        chk("idle_clear_then_hit", bus.ICIF_en, 1);
        chk("idle_clear_hit_data", bus.ICIF_data, word_at(32'h0000_3028));
        bus.IFIC_en = 1'b0;
        tick();

        // MCIC_en in IDLE is ignored and does not touch the line.
        bus.MCIC_en    = 1'b1;
        bus.MCIC_block = 64'hdead_beef_cafe_f00d;
        tick();
        bus.MCIC_en = 1'b0;
        chk("stray_mc_no_resp", bus.ICIF_en, 0);
        chk("stray_mc_no_req",  bus.ICMC_en, 0);
        fetch(32'h0000_3028, 1, -1);

        // Sys_rdy low for 3 cycles delays a hit by exactly 3 cycles.
        bus.IFIC_en   = 1'b1;
        bus.IFIC_addr = 32'h0000_1000;
        rdy           = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_low_hold", bus.ICIF_en, 0);
        end
        rdy = 1'b1;
        tick();
        chk("rdy_delayed_en",   bus.ICIF_en,   1);
        chk("rdy_delayed_data", bus.ICIF_data, word_at(32'h0000_1000));
        bus.IFIC_en = 1'b0;
        tick();

        // Async reset mid-miss: ICMC_en drops with no clock edge.
        bus.IFIC_en   = 1'b1;
        bus.IFIC_addr = 32'h0000_4000;
        tick();
        chk("pre_reset_req", bus.ICMC_en, 1);
        bus.IFIC_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_req_low", bus.ICMC_en, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        tick();
        fetch(32'h0000_1000, 2, -1);   // previously a hit, must miss now

        // Randomized traffic over a few conflicting lines.
        for (int t = 0; t < 40; t++) begin
            a   = {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 2)],
                   1'($urandom_range(0, 1)), 2'b00};
            lat = int'($urandom_range(1, 4));
            clr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            fetch(a, lat, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher (IF) and the memory controller (MC).
- Serves one 32-bit instruction per request.
- On a miss, fetches a whole 2-instruction block from MC over the ICMC/MCIC handshake, fills the line, then answers IF.
- A clear input squashes the pending answer after a branch mispredict, without corrupting the line.

Parameters:
- BLOCK_WIDTH, 1: log2 instructions per block; block = 64 bits, offset bit addr[2].
- BLOCK_SIZE, 1<<BLOCK_WIDTH: instructions per block.
- CACHE_WIDTH, 8: log2 line count; index = addr[10:3].
- BLOCK_NUM, 1<<CACHE_WIDTH: number of lines.
- ADDR_WIDTH, 32: address width; tag = addr[31:11].

Ports:
- Sys_clk in 1: clock, rising edge.
- Sys_rst in 1: asynchronous, active-low reset.
- Sys_rdy in 1: global enable; when 0, all state holds.
- IFIC_en in 1: fetch request, level, held until ICIF_en.
- IFIC_addr in 32: fetch PC, word aligned.
- ICIF_en out 1: one-cycle pulse, data valid.
- ICIF_data out 32: instruction.
- ROBIC_clear in 1: flush pending request.
- ICMC_en out 1: block-read request to MC.
- ICMC_addr out 32: block base address {addr[31:3],3'b0}.
- MCIC_en in 1: one-cycle pulse, block valid.
- MCIC_block in 64: fetched block.

Behaviour:
- Storage:
  - valid[BLOCK_NUM], tag[BLOCK_NUM][21 bits], data[BLOCK_NUM][64 bits].
  - Only valid bits, state and outputs are reset; tag/data arrays are not.
- Reset (Sys_rst=0, async):
  - all valid=0, state=IDLE.
  - ICIF_en=0, ICIF_data=0, ICMC_addr=0; pending-squash flag=0.
- Block byte mapping from MC (byte at base+k lands in MCIC_block[63-8k:56-8k]):
  - instr0 = {blk[39:32],blk[47:40],blk[55:48],blk[63:56]}
  - instr1 = {blk[7:0],blk[15:8],blk[23:16],blk[31:24]}
  - addr[2] selects instr0 or instr1.
- ICIF_en defaults to 0 every active cycle; it is a pulse, never held.
- State IDLE:
  - IFIC_en=1, ROBIC_clear=0, hit (valid[idx] and tag match): next edge ICIF_en<=1, ICIF_data<=selected instr. Hit latency is 1 cycle. IF must drop or change the request on the cycle it sees ICIF_en.
  - IFIC_en=1, miss: latch request address; ICMC_addr<=block base; go MISS.
  - ROBIC_clear=1: no action.
- State MISS:
  - ICMC_en = (state==MISS) && !MCIC_en. This is combinational, so ICMC_en is already low on the edge where MC returns to idle, and no redundant fetch starts.
  - On MCIC_en=1: write data/tag, set valid for the latched index; go IDLE.
    - If not squashed: same edge ICIF_en<=1, ICIF_data<=selected instr from MCIC_block. Miss latency is MC latency + 1 edge.
    - If squashed: no ICIF_en.
  - ROBIC_clear=1 in MISS: set squash flag, stay in MISS. The MC transfer cannot be aborted; the line is still filled. The flag clears on leaving MISS.
  - IFIC_addr changes during MISS are ignored; the latched address is used. IF re-requests after the flush.
- Simultaneous ROBIC_clear and MCIC_en: fill happens, response suppressed.
- ROBIC_clear in IDLE the same cycle a hit would answer: clear wins, no ICIF_en.
- Sys_rdy=0: no state, array or output change. ICMC_en keeps following its combinational equation.
- Reset mid-MISS: immediate return to IDLE with all lines invalid. Any MC transfer in flight is reset system-wide at the same time.
- MCIC_en seen in IDLE is ignored.

Test Plan:
- Cold miss:
  - Stimulus: reset; IFIC_en=1, addr 0x00001004; MC returns block bytes 0x13,0x05,0x00,0x00,0x93,0x00,0x10,0x00 (base+0..7), i.e. MCIC_block=0x1305000093001000.
  - Required: ICMC_en high with ICMC_addr=0x00001000; ICMC_en low during the MCIC_en cycle; next edge ICIF_en=1, ICIF_data=0x00100093.
- Hit after fill:
  - Stimulus: request 0x00001000.
  - Required: ICIF_en exactly 1 cycle later, data=0x00000513; ICMC_en stays 0.
- Conflict eviction:
  - Stimulus: request 0x00001800 (same index 0x00, different tag).
  - Required: miss, ICMC_addr=0x00001800. Then re-request 0x00001000 -> miss again.
- Flush during miss:
  - Stimulus: assert ROBIC_clear 2 cycles after ICMC_en rises.
  - Required: no ICIF_en when MCIC_en arrives; a subsequent request to the same block hits in 1 cycle.
- Simultaneous clear and fill:
  - Stimulus: ROBIC_clear and MCIC_en on the same cycle.
  - Required: no ICIF_en; the line is valid.
- Reset and Sys_rdy:
  - Stimulus: async reset pulse mid-MISS.
  - Required: ICMC_en drops without a clock edge; the previously hit address now misses.
  - Stimulus: Sys_rdy=0 for 3 cycles during a hit.
  - Required: ICIF_en delayed by exactly 3 cycles.
